adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_pkg.sv | 21 ++
 rtl/sync_edge.sv | 38 +++
 rtl/adc_spi_responder.sv | 206 ++++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
`default_nettype none
// ============================================================================
// Package : adc_spi_pkg
// Desc    : FSM state encoding and command constants shared by the ADC SPI
//           responder and its helpers.
// Rev     : 1.0  initial release
// ============================================================================
package adc_spi_pkg;

  localparam int CMD_BITS  = 3;
  localparam int CMD_CNT_W = $clog2(CMD_BITS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_NULLB = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_TAIL  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module : sync_edge
// Desc   : Multi-flop synchroniser with rise/fall detection on its output.
// Rev    : 1.0  initial release
// ============================================================================
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module : adc_spi_responder
// Desc   : MCP3002-style SPI ADC responder, fully oversampled on controlCLK.
// Rev    : 1.0  initial release
// ============================================================================
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              controlCLK,
  input  logic              rst,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              DIN,
  output logic              DOUT,
  output logic              DOUT_OE,
  input  logic [DATA_W-1:0] ch0_sample,
  input  logic [DATA_W-1:0] ch1_sample,
  output logic              sample_req,
  output logic              sel_ch,
  output logic              busy,
  output logic              cmd_err
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_s;
  logic                   din_s;

  logic [2:0]           state_q,   state_d;
  logic [CMD_CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    sr_q,      sr_d;
  logic                 msbf_q,    msbf_d;
  logic                 sel_ch_q,  sel_ch_d;
  logic                 dout_q,    dout_d;
  logic                 oe_q,      oe_d;
  logic                 req_q,     req_d;
  logic                 err_q,     err_d;
  logic                 armed_q,   armed_d;
  logic [DATA_W-1:0]    sr_rot;

  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk_i  (controlCLK),
    .rst_i  (rst),
    .d_i    (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // settle_q fills with ones once the reset values have flushed out of the chains
  always_ff @(posedge controlCLK or posedge rst) begin
    if (rst) begin
      cs_sync_q  <= '1;
      din_sync_q <= '0;
      settle_q   <= '0;
    end else begin
      cs_sync_q[0]  <= CS;
      din_sync_q[0] <= DIN;
      settle_q[0]   <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync_q[i]  <= cs_sync_q[i-1];
        din_sync_q[i] <= din_sync_q[i-1];
        settle_q[i]   <= settle_q[i-1];
      end
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];
  assign sr_rot = {sr_q[DATA_W-2:0], sr_q[DATA_W-1]};

  always_comb begin
    state_d   = state_q;
    cmd_cnt_d = cmd_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    msbf_d    = msbf_q;
    sel_ch_d  = sel_ch_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    req_d     = 1'b0;
    err_d     = err_q;
    // A frame may only start after CS has been seen high since reset
    armed_d   = armed_q | (settle_q[SYNC_STAGES-1] & cs_s);

    if (state_q != ST_IDLE && cs_s) begin
      state_d = ST_IDLE;
      sr_d    = '0;
      dout_d  = 1'b0;
      oe_d    = 1'b0;
      if (state_q == ST_CMD || state_q == ST_NULLB || state_q == ST_DATA) begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          dout_d = 1'b0;
          oe_d   = 1'b0;
          if (!cs_s && armed_q) begin
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (sclk_rise && din_s) begin
            state_d   = ST_CMD;
            cmd_cnt_d = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cmd_cnt_d = cmd_cnt_q + CMD_CNT_W'(1);
            if (cmd_cnt_q == CMD_CNT_W'(1)) begin
              sel_ch_d = din_s;
            end
            if (cmd_cnt_q == CMD_CNT_W'(CMD_BITS-1)) begin
              msbf_d  = din_s;
              sr_d    = sel_ch_q ? ch1_sample : ch0_sample;
              req_d   = 1'b1;
              state_d = ST_NULLB;
            end
          end
        end
        ST_NULLB: begin
          if (sclk_fall) begin
            dout_d    = 1'b0;
            oe_d      = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          if (sclk_fall) begin
            dout_d    = sr_q[DATA_W-1];
            sr_d      = sr_rot;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            // After a full rotation sr_rot is the original word again
            if (bit_cnt_q == BIT_W'(DATA_W-1)) begin
              sr_d    = msbf_q ? '0 : (sr_rot >> 1);
              state_d = ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          if (sclk_fall) begin
            dout_d = sr_q[0];
            sr_d   = sr_q >> 1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          dout_d  = 1'b0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge controlCLK or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_cnt_q <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      msbf_q    <= 1'b0;
      sel_ch_q  <= 1'b0;
      dout_q    <= 1'b0;
      oe_q      <= 1'b0;
      req_q     <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_cnt_q <= cmd_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      msbf_q    <= msbf_d;
      sel_ch_q  <= sel_ch_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      req_q     <= req_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_OE    = oe_q;
  assign sample_req = req_q;
  assign sel_ch     = sel_ch_q;
  assign busy       = (state_q != ST_IDLE);
  assign cmd_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_spi_responder
// Desc   : Directed + randomized SPI frames against a bit-stream reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_adc_spi_responder;

  localparam int W = 10;
  localparam int S = 2;

  logic         controlCLK = 1'b0;
  logic         rst;
  logic         CS;
  logic         SCLK;
  logic         DIN;
  logic         DOUT;
  logic         DOUT_OE;
  logic [W-1:0] ch0_sample;
  logic [W-1:0] ch1_sample;
  logic         sample_req;
  logic         sel_ch;
  logic         busy;
  logic         cmd_err;

  int   checks   = 0;
  int   failures = 0;
  int   req_cnt  = 0;
  bit   mutate   = 1'b0;
  logic rd_dout [0:63];
  logic rd_oe   [0:63];

  adc_spi_responder #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .controlCLK (controlCLK),
    .rst        (rst),
    .CS         (CS),
    .SCLK       (SCLK),
    .DIN        (DIN),
    .DOUT       (DOUT),
    .DOUT_OE    (DOUT_OE),
    .ch0_sample (ch0_sample),
    .ch1_sample (ch1_sample),
    .sample_req (sample_req),
    .sel_ch     (sel_ch),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  always #5 controlCLK = ~controlCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One controlCLK cycle; counts request pulses and optionally disturbs ch0 right after one
  task automatic tick();
    @(negedge controlCLK);
    if (sample_req === 1'b1) begin
      req_cnt++;
      if (mutate) ch0_sample = ch0_sample ^ W'($urandom_range(1, (1 << W) - 1));
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Drives CS low and nr SCLK periods; records DOUT/DOUT_OE just before each rising edge
  task automatic clock_frame(input int lz, input bit sgl, input bit odd, input bit msbf,
                             input int nr, input int ph);
    logic tx [0:63];
    for (int i = 0; i < 64; i++) tx[i] = 1'b0;
    tx[lz]   = 1'b1;
    tx[lz+1] = sgl;
    tx[lz+2] = odd;
    tx[lz+3] = msbf;
    CS = 1'b0;
    ticks(ph);
    for (int k = 0; k < nr; k++) begin
      SCLK = 1'b0;
      DIN  = tx[k];
      ticks(ph);
      rd_dout[k] = DOUT;
      rd_oe[k]   = DOUT_OE;
      SCLK = 1'b1;
      ticks(ph);
    end
    SCLK = 1'b0;
    DIN  = 1'b0;
    ticks(ph);
  endtask

  // Reference: bit the master reads on rise k, where rise c-1 carried the MSBF bit
  function automatic logic exp_bit(input logic [W-1:0] v, input bit msbf, input int c, input int k);
    int j;
    if (k <= c) return 1'b0;
    j = k - c - 1;
    if (j < W) return v[W-1-j];
    j = j - W;
    if (!msbf && j < W - 1) return v[1+j];
    return 1'b0;
  endfunction

  task automatic check_frame(input string tag, input logic [W-1:0] v, input int lz,
                             input bit msbf, input int nr, input bit active);
    logic [63:0] od, oo, xd, xo;
    int c;
    c  = lz + 4;
    od = '0; oo = '0; xd = '0; xo = '0;
    for (int k = 0; k < nr; k++) begin
      od[k] = rd_dout[k];
      oo[k] = rd_oe[k];
      xd[k] = active ? exp_bit(v, msbf, c, k) : 1'b0;
      xo[k] = active && (k >= c);
    end
    chk({tag, "_dout"}, od, xd);
    chk({tag, "_oe"}, oo, xo);
  endtask

  task automatic cs_release(input string tag, input bit exp_err);
    CS = 1'b1;
    ticks(S + 1);
    chk({tag, "_rel_oe"}, 64'(DOUT_OE), 64'(0));
    chk({tag, "_rel_dout"}, 64'(DOUT), 64'(0));
    chk({tag, "_rel_busy"}, 64'(busy), 64'(0));
    chk({tag, "_rel_err"}, 64'(cmd_err), 64'(exp_err));
    ticks(4);
  endtask

  task automatic full_frame(input string tag, input int lz, input bit sgl, input bit odd,
                            input bit msbf, input int ph, input bit exp_err);
    logic [W-1:0] v;
    int nr;
    v  = odd ? ch1_sample : ch0_sample;
    nr = lz + 4 + 1 + 2 * W + 1;
    req_cnt = 0;
    clock_frame(lz, sgl, odd, msbf, nr, ph);
    check_frame(tag, v, lz, msbf, nr, 1'b1);
    chk({tag, "_req"}, 64'(req_cnt), 64'(1));
    chk({tag, "_sel"}, 64'(sel_ch), 64'(odd));
    cs_release(tag, exp_err);
  endtask

  initial begin
    logic [W-1:0] v;
    rst = 1'b1; CS = 1'b1; SCLK = 1'b0; DIN = 1'b0;
    ch0_sample = '0; ch1_sample = '0;
    #1;
    chk("rst_dout", 64'(DOUT), 64'(0));
    chk("rst_oe", 64'(DOUT_OE), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(cmd_err), 64'(0));
    chk("rst_sel", 64'(sel_ch), 64'(0));
    chk("rst_req", 64'(sample_req), 64'(0));
    ticks(3);
    rst = 1'b0;
    ticks(5);

    // Scenario 1 and 3: MSB-first from ch0, with and without leading zeros
    ch0_sample = 10'h2A5;
    full_frame("s1", 0, 1'b1, 1'b0, 1'b1, 5, 1'b0);
    full_frame("s3", 3, 1'b1, 1'b0, 1'b1, 5, 1'b0);

    // Scenario 2: LSB-first tail from ch1
    ch1_sample = 10'h001;
    full_frame("s2", 0, 1'b1, 1'b1, 1'b0, 5, 1'b0);

    // Scenario 4: abort after the fourth data bit, then a clean frame
    ch0_sample = W'($urandom);
    req_cnt = 0;
    clock_frame(0, 1'b1, 1'b0, 1'b1, 9, 5);
    check_frame("s4a", ch0_sample, 0, 1'b1, 9, 1'b1);
    cs_release("s4a", 1'b1);
    ch0_sample = W'($urandom);
    full_frame("s4b", 0, 1'b0, 1'b0, 1'b1, 5, 1'b1);

    // Scenario 5: reset mid-DATA with CS held low
    ch1_sample = W'($urandom);
    clock_frame(0, 1'b0, 1'b1, 1'b0, 9, 5);
    rst = 1'b1;
    #1;
    chk("s5_rst_oe", 64'(DOUT_OE), 64'(0));
    chk("s5_rst_dout", 64'(DOUT), 64'(0));
    chk("s5_rst_busy", 64'(busy), 64'(0));
    chk("s5_rst_err", 64'(cmd_err), 64'(0));
    chk("s5_rst_sel", 64'(sel_ch), 64'(0));
    ticks(2);
    rst = 1'b0;
    ticks(4);
    req_cnt = 0;
    clock_frame(0, 1'b1, 1'b1, 1'b1, 18, 5);
    check_frame("s5_idle", ch1_sample, 0, 1'b1, 18, 1'b0);
    chk("s5_idle_req", 64'(req_cnt), 64'(0));
    chk("s5_idle_busy", 64'(busy), 64'(0));
    cs_release("s5_idle", 1'b0);
    full_frame("s5_after", 0, 1'b1, 1'b1, 1'b1, 5, 1'b0);

    // Scenario 6: minimum SCLK phase, ch0 disturbed right after the latch
    ch0_sample = W'($urandom);
    v = ch0_sample;
    mutate = 1'b1;
    req_cnt = 0;
    clock_frame(0, 1'b1, 1'b0, 1'b0, 4 + 1 + 2 * W + 1, 4);
    mutate = 1'b0;
    check_frame("s6", v, 0, 1'b0, 4 + 1 + 2 * W + 1, 1'b1);
    chk("s6_req", 64'(req_cnt), 64'(1));
    cs_release("s6", 1'b0);

    // Randomized frames
    for (int n = 0; n < 6; n++) begin
      ch0_sample = W'($urandom);
      ch1_sample = W'($urandom);
      full_frame("rnd", $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(4, 7), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
